// File: rtl/pwm_pkg.sv
// Shared types and default constants for the PWM duty-cycle sequencer.
package pwm_pkg;

  typedef enum logic [1:0] {
    MANUAL      = 2'd0,
    BREATH_UP   = 2'd1,
    BREATH_DOWN = 2'd2
  } state_e;

  localparam int PWM_W     = 8;
  localparam int DUTY_STEP = 16;
  localparam int DUTY_MAX  = 240;

endpackage

// File: rtl/pwm_duty_seq_if.sv
// Bundle of button inputs, period strobe and width outputs for pwm_duty_seq.
// period_end and width_upd are single-cycle strobes with no back-pressure: a strobe
// counts in the cycle it is high, and the receiver must always accept it.
interface pwm_duty_seq_if #(
  parameter int WIDTH = 8
);
  import pwm_pkg::*;

  logic             key_up;
  logic             key_down;
  logic             key_mode;
  logic             period_end;
  logic [WIDTH-1:0] pwm_width;
  logic             width_upd;
  logic             breath_mode;
  state_e           dbg_state;
  logic [WIDTH-1:0] dbg_target;

  modport master (
    output key_up, key_down, key_mode, period_end,
    input  pwm_width, width_upd, breath_mode, dbg_state, dbg_target
  );

  modport slave (
    input  key_up, key_down, key_mode, period_end,
    output pwm_width, width_upd, breath_mode, dbg_state, dbg_target
  );

endinterface

// File: rtl/pwm_duty_seq_key_debounce.sv
// One push-button: 2-FF synchronizer, stability counter and a 1-cycle press pulse
// on an accepted 0->1 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    // The counter only runs while the synced level disagrees with the accepted one.
    if (s2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        stable_d = s2_q;
        press_d  = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      s1_q     <= key_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pwm_duty_seq.sv
// Duty-width source for the PWM generator: manual up/down stepping or an automatic
// triangle ramp, with the width presented only at PWM period boundaries.
module pwm_duty_seq
  import pwm_pkg::*;
#(
  parameter int WIDTH        = PWM_W,
  parameter int STEP         = DUTY_STEP,
  parameter int MAX_WIDTH    = DUTY_MAX,
  parameter int RAMP_DIV     = 4,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  pwm_duty_seq_if.slave     bus
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] MAX_X  = (WIDTH + 1)'(MAX_WIDTH);

  logic up_p, down_p, mode_p;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
    .clk(clk), .rst(rst), .key_i(bus.key_up), .press_o(up_p)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_down (
    .clk(clk), .rst(rst), .key_i(bus.key_down), .press_o(down_p)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_mode (
    .clk(clk), .rst(rst), .key_i(bus.key_mode), .press_o(mode_p)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [RW-1:0]    ramp_q, ramp_d;
  logic [WIDTH-1:0] width_q;
  logic             upd_q;

  // One extra bit so neither direction can wrap before the clamp.
  logic [WIDTH:0] sum_up, diff_dn;
  assign sum_up  = {1'b0, target_q} + STEP_X;
  assign diff_dn = {1'b0, target_q} - STEP_X;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    ramp_d   = ramp_q;
    case (state_q)
      MANUAL: begin
        if (mode_p) begin
          state_d = BREATH_UP;
          ramp_d  = '0;
        end else if (up_p && !down_p) begin
          target_d = (sum_up > MAX_X) ? MAX_X[WIDTH-1:0] : sum_up[WIDTH-1:0];
        end else if (down_p && !up_p) begin
          target_d = ({1'b0, target_q} < STEP_X) ? '0 : diff_dn[WIDTH-1:0];
        end
      end
      BREATH_UP, BREATH_DOWN: begin
        if (mode_p) begin
          state_d = MANUAL;
        end else if (bus.period_end) begin
          if (ramp_q == RW'(RAMP_DIV - 1)) begin
            ramp_d = '0;
            if (state_q == BREATH_UP) begin
              if (sum_up >= MAX_X) begin
                target_d = MAX_X[WIDTH-1:0];
                state_d  = BREATH_DOWN;
              end else begin
                target_d = sum_up[WIDTH-1:0];
              end
            end else begin
              if ({1'b0, target_q} <= STEP_X) begin
                target_d = '0;
                state_d  = BREATH_UP;
              end else begin
                target_d = diff_dn[WIDTH-1:0];
              end
            end
          end else begin
            ramp_d = ramp_q + 1'b1;
          end
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MANUAL;
      target_q <= '0;
      ramp_q   <= '0;
      width_q  <= '0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      ramp_q   <= ramp_d;
      upd_q    <= bus.period_end;
      // Loads the pre-edge target, so a same-cycle change waits one full period.
      if (bus.period_end) width_q <= target_q;
    end
  end

  assign bus.pwm_width   = width_q;
  assign bus.width_upd   = upd_q;
  assign bus.breath_mode = (state_q == BREATH_UP) || (state_q == BREATH_DOWN);
  assign bus.dbg_state   = state_q;
  assign bus.dbg_target  = target_q;

endmodule
